// File: rtl/xc_fifo_wr_arb_pkg.sv
// Shared definitions for the FIFO write-side controller: flush sequencer
// state encoding and reset values of the watermark threshold registers.
package xc_fifo_wr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLR    = 2'd1,
        SETTLE = 2'd2
    } flush_state_e;

    localparam int unsigned AE_THR_DEFAULT = 32'd1;

    // Almost-full defaults to the highest representable threshold (all ones).
    function automatic int unsigned af_thr_default(input int unsigned log2_depth);
        return (32'd1 << log2_depth) - 32'd1;
    endfunction

endpackage

// File: rtl/xc_fifo_wr_arb.sv
// FIFO write-port owner: round-robin between the SPI shifter and the host push
// register, flush sequencing, threshold registers and sticky watermark IRQs.
module xc_fifo_wr_arb
    import xc_fifo_wr_arb_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned LOG2_DEPTH = 3
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  req0_i,
    input  logic                  req1_i,
    input  logic [WIDTH-1:0]      data0_i,
    input  logic [WIDTH-1:0]      data1_i,
    output logic                  gnt0_o,
    output logic                  gnt1_o,
    input  logic                  flush_i,
    output logic                  flush_busy_o,
    input  logic                  cfg_we_i,
    input  logic [LOG2_DEPTH-1:0] cfg_af_i,
    input  logic [LOG2_DEPTH-1:0] cfg_ae_i,
    input  logic                  irq_clr_i,
    output logic                  irq_af_o,
    output logic                  irq_ae_o,
    output logic                  fifo_wr_o,
    output logic [WIDTH-1:0]      fifo_data_o,
    output logic                  fifo_clr_o,
    input  logic                  fifo_full_i,
    input  logic                  fifo_af_i,
    input  logic                  fifo_ae_i,
    output logic [LOG2_DEPTH-1:0] fifo_af_count_o,
    output logic [LOG2_DEPTH-1:0] fifo_ae_count_o
);

    localparam logic [LOG2_DEPTH-1:0] AF_THR_RST = LOG2_DEPTH'(af_thr_default(LOG2_DEPTH));
    localparam logic [LOG2_DEPTH-1:0] AE_THR_RST = LOG2_DEPTH'(AE_THR_DEFAULT);

    flush_state_e          state_r;
    logic                  last_r;
    logic                  clr_r;
    logic                  busy_r;
    logic [LOG2_DEPTH-1:0] af_thr_r;
    logic [LOG2_DEPTH-1:0] ae_thr_r;
    logic                  af_q_r;
    logic                  ae_q_r;
    logic                  irq_af_r;
    logic                  irq_ae_r;

    logic                  eligible_s;
    logic                  gnt0_s;
    logic                  gnt1_s;
    logic                  af_rise_s;
    logic                  ae_rise_s;

    // Round-robin grant; on a tie the requester that did not win last time goes.
    always_comb begin
        gnt0_s     = 1'b0;
        gnt1_s     = 1'b0;
        eligible_s = (state_r == IDLE) && !flush_i && !fifo_full_i;
        if (eligible_s) begin
            if (req0_i && req1_i) begin
                gnt0_s = last_r;
                gnt1_s = !last_r;
            end else begin
                gnt0_s = req0_i;
                gnt1_s = req1_i;
            end
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // Watermark edge detection, masked while the FIFO is being cleared.
    always_comb begin
        af_rise_s = 1'b0;
        ae_rise_s = 1'b0;
        if (state_r == IDLE) begin
            af_rise_s = fifo_af_i && !af_q_r;
            ae_rise_s = fifo_ae_i && !ae_q_r;
        end else begin
            af_rise_s = 1'b0;
            ae_rise_s = 1'b0;
        end
    end

    // Flush sequencer with registered clear/busy strobes and last-grant tracking.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r <= IDLE;
            clr_r   <= 1'b0;
            busy_r  <= 1'b0;
            last_r  <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (flush_i) begin
                        state_r <= CLR;
                        clr_r   <= 1'b1;
                        busy_r  <= 1'b1;
                        last_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        clr_r   <= 1'b0;
                        busy_r  <= 1'b0;
                        if (gnt0_s || gnt1_s) begin
                            last_r <= gnt1_s;
                        end else begin
                            last_r <= last_r;
                        end
                    end
                end
                CLR: begin
                    state_r <= SETTLE;
                    clr_r   <= 1'b0;
                    busy_r  <= 1'b1;
                end
                SETTLE: begin
                    state_r <= IDLE;
                    clr_r   <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    clr_r   <= 1'b0;
                    busy_r  <= 1'b0;
                    last_r  <= 1'b1;
                end
            endcase
        end
    end

    // Threshold registers, loadable in any flush state.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            af_thr_r <= AF_THR_RST;
            ae_thr_r <= AE_THR_RST;
        end else if (cfg_we_i) begin
            af_thr_r <= cfg_af_i;
            ae_thr_r <= cfg_ae_i;
        end else begin
            af_thr_r <= af_thr_r;
            ae_thr_r <= ae_thr_r;
        end
    end

    // Sticky interrupts; ae_q starts high because the FIFO is empty out of reset.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            af_q_r   <= 1'b0;
            ae_q_r   <= 1'b1;
            irq_af_r <= 1'b0;
            irq_ae_r <= 1'b0;
        end else begin
            af_q_r <= fifo_af_i;
            ae_q_r <= fifo_ae_i;
            if (af_rise_s) begin
                irq_af_r <= 1'b1;
            end else if (irq_clr_i) begin
                irq_af_r <= 1'b0;
            end else begin
                irq_af_r <= irq_af_r;
            end
            if (ae_rise_s) begin
                irq_ae_r <= 1'b1;
            end else if (irq_clr_i) begin
                irq_ae_r <= 1'b0;
            end else begin
                irq_ae_r <= irq_ae_r;
            end
        end
    end

    assign gnt0_o          = gnt0_s;
    assign gnt1_o          = gnt1_s;
    assign fifo_wr_o       = gnt0_s | gnt1_s;
    assign fifo_data_o     = gnt1_s ? data1_i : data0_i;
    assign fifo_clr_o      = clr_r;
    assign flush_busy_o    = busy_r;
    assign fifo_af_count_o = af_thr_r;
    assign fifo_ae_count_o = ae_thr_r;
    assign irq_af_o        = irq_af_r;
    assign irq_ae_o        = irq_ae_r;

endmodule

// File: tb/tb_xc_fifo_wr_arb.sv
// Bench for xc_fifo_wr_arb: an 8-entry FIFO occupancy model supplies the status
// flags; directed scenarios plus random traffic are checked against a flush-countdown model.
module tb_xc_fifo_wr_arb;

    localparam int W = 32;
    localparam int L = 3;

    logic         clk_i = 1'b0;
    logic         rstn_i = 1'b0;
    logic         req0_i = 1'b0, req1_i = 1'b0;
    logic [W-1:0] data0_i = '0, data1_i = '0;
    logic         gnt0_o, gnt1_o;
    logic         flush_i = 1'b0;
    logic         flush_busy_o;
    logic         cfg_we_i = 1'b0;
    logic [L-1:0] cfg_af_i = '0, cfg_ae_i = '0;
    logic         irq_clr_i = 1'b0;
    logic         irq_af_o, irq_ae_o;
    logic         fifo_wr_o;
    logic [W-1:0] fifo_data_o;
    logic         fifo_clr_o;
    logic         fifo_full_i, fifo_af_i, fifo_ae_i;
    logic [L-1:0] fifo_af_count_o, fifo_ae_count_o;

    logic [3:0]   fifo_cnt;
    logic         rd_en = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: flush countdown (2 = clearing, 1 = settling).
    int           m_busy;
    int           m_last;
    bit           m_irq_af, m_irq_ae, m_prev_af, m_prev_ae;
    logic [L-1:0] m_af_thr, m_ae_thr;

    always #5 clk_i = ~clk_i;

    xc_fifo_wr_arb #(.WIDTH(W), .LOG2_DEPTH(L)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .req0_i(req0_i), .req1_i(req1_i), .data0_i(data0_i), .data1_i(data1_i),
        .gnt0_o(gnt0_o), .gnt1_o(gnt1_o),
        .flush_i(flush_i), .flush_busy_o(flush_busy_o),
        .cfg_we_i(cfg_we_i), .cfg_af_i(cfg_af_i), .cfg_ae_i(cfg_ae_i),
        .irq_clr_i(irq_clr_i), .irq_af_o(irq_af_o), .irq_ae_o(irq_ae_o),
        .fifo_wr_o(fifo_wr_o), .fifo_data_o(fifo_data_o), .fifo_clr_o(fifo_clr_o),
        .fifo_full_i(fifo_full_i), .fifo_af_i(fifo_af_i), .fifo_ae_i(fifo_ae_i),
        .fifo_af_count_o(fifo_af_count_o), .fifo_ae_count_o(fifo_ae_count_o)
    );

    // FIFO occupancy model driving the status flags.
    always @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) fifo_cnt <= 4'd0;
        else if (fifo_clr_o) fifo_cnt <= 4'd0;
        else fifo_cnt <= fifo_cnt + {3'd0, fifo_wr_o} - {3'd0, (rd_en && fifo_cnt != 4'd0)};
    end
    assign fifo_full_i = (fifo_cnt == 4'd8);
    assign fifo_af_i   = (fifo_cnt >= {1'b0, fifo_af_count_o});
    assign fifo_ae_i   = (fifo_cnt <= {1'b0, fifo_ae_count_o});

    task automatic model_reset();
        m_busy = 0; m_last = 1; m_irq_af = 1'b0; m_irq_ae = 1'b0;
        m_prev_af = 1'b0; m_prev_ae = 1'b1; m_af_thr = 3'd7; m_ae_thr = 3'd1;
    endtask

    function automatic int exp_gnt();
        if (m_busy != 0 || flush_i || fifo_full_i) return -1;
        if (req0_i && req1_i) return (m_last == 0) ? 1 : 0;
        if (req0_i) return 0;
        if (req1_i) return 1;
        return -1;
    endfunction

    function automatic logic [1:0] gnt_bits(input int g);
        return (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
    endfunction

    // Advance the model by one clock using the inputs present at this edge.
    task automatic model_tick();
        int g;
        bit quiet;
        g = exp_gnt();
        quiet = (m_busy != 0);
        if (fifo_af_i && !m_prev_af && !quiet) m_irq_af = 1'b1;
        else if (irq_clr_i) m_irq_af = 1'b0;
        if (fifo_ae_i && !m_prev_ae && !quiet) m_irq_ae = 1'b1;
        else if (irq_clr_i) m_irq_ae = 1'b0;
        m_prev_af = fifo_af_i;
        m_prev_ae = fifo_ae_i;
        if (g >= 0) m_last = g;
        if (m_busy > 0) m_busy = m_busy - 1;
        else if (flush_i) begin m_busy = 2; m_last = 1; end
        if (cfg_we_i) begin m_af_thr = cfg_af_i; m_ae_thr = cfg_ae_i; end
    endtask

    task automatic step();
        model_tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rstn_i = 1'b0;
        data0_i = 32'h1234_5678; data1_i = 32'h9abc_def0;
        model_reset();
        repeat (2) @(negedge clk_i);
        n_cmp++;
        if ({gnt0_o, gnt1_o, fifo_wr_o, fifo_clr_o, flush_busy_o, irq_af_o, irq_ae_o} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_outs: got %b want 0000000",
                     {gnt0_o, gnt1_o, fifo_wr_o, fifo_clr_o, flush_busy_o, irq_af_o, irq_ae_o});
        end
        n_cmp++;
        if (fifo_data_o !== 32'h1234_5678) begin
            n_err++; $display("FAIL reset_data: got %h want 12345678", fifo_data_o);
        end
        n_cmp++;
        if (fifo_af_count_o !== 3'b111) begin
            n_err++; $display("FAIL reset_af_count: got %0d want 7", fifo_af_count_o);
        end
        n_cmp++;
        if (fifo_ae_count_o !== 3'd1) begin
            n_err++; $display("FAIL reset_ae_count: got %0d want 1", fifo_ae_count_o);
        end
        @(posedge clk_i); #1;
        rstn_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            n_cmp++;
            if (irq_ae_o !== 1'b0) begin
                n_err++; $display("FAIL reset_no_ae_irq: got %b want 0 (cycle %0d)", irq_ae_o, i);
            end
            step();
        end
    endtask

    task automatic test_round_robin();
        int e;
        req0_i = 1'b1; req1_i = 1'b1; data0_i = 32'hA; data1_i = 32'hB;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk_i);
            e = (i < 8) ? (i % 2) : -1;
            n_cmp++;
            if ({gnt1_o, gnt0_o} !== gnt_bits(e)) begin
                n_err++; $display("FAIL rr_grant[%0d]: got %b want %b", i, {gnt1_o, gnt0_o}, gnt_bits(e));
            end
            if (e >= 0) begin
                n_cmp++;
                if (fifo_data_o !== ((e == 1) ? 32'hB : 32'hA)) begin
                    n_err++; $display("FAIL rr_data[%0d]: got %h want %0d", i, fifo_data_o, (e == 1) ? 11 : 10);
                end
            end
            step();
        end
        req0_i = 1'b0; req1_i = 1'b0;
        @(negedge clk_i);
        n_cmp++;
        if (irq_af_o !== 1'b1) begin
            n_err++; $display("FAIL rr_irq_af_set: got %b want 1", irq_af_o);
        end
        irq_clr_i = 1'b1;
        step();
        irq_clr_i = 1'b0;
        @(negedge clk_i);
        n_cmp++;
        if (irq_af_o !== 1'b0) begin
            n_err++; $display("FAIL rr_irq_af_clr: got %b want 0", irq_af_o);
        end
        step();
    endtask

    task automatic test_flush();
        req0_i = 1'b1; flush_i = 1'b1;
        @(negedge clk_i);
        n_cmp++;
        if ({gnt1_o, gnt0_o, fifo_wr_o} !== 3'b000) begin
            n_err++; $display("FAIL flush_c0_nogrant: got %b want 000", {gnt1_o, gnt0_o, fifo_wr_o});
        end
        step();
        flush_i = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk_i);
            n_cmp++;
            if (fifo_clr_o !== ((c == 1) ? 1'b1 : 1'b0) || flush_busy_o !== ((c <= 2) ? 1'b1 : 1'b0)) begin
                n_err++; $display("FAIL flush_c%0d_clr_busy: got %b%b want %b%b", c, fifo_clr_o, flush_busy_o,
                                  (c == 1), (c <= 2));
            end
            n_cmp++;
            if (gnt0_o !== ((c == 3) ? 1'b1 : 1'b0)) begin
                n_err++; $display("FAIL flush_c%0d_gnt0: got %b want %b", c, gnt0_o, (c == 3));
            end
            n_cmp++;
            if (irq_ae_o !== 1'b0) begin
                n_err++; $display("FAIL flush_c%0d_ae_masked: got %b want 0", c, irq_ae_o);
            end
            step();
            if (c == 3) req0_i = 1'b0;
        end
    endtask

    task automatic test_af_irq();
        int rise_at;
        cfg_we_i = 1'b1; cfg_af_i = 3'd5; cfg_ae_i = 3'd1; flush_i = 1'b1;
        @(negedge clk_i); step();
        cfg_we_i = 1'b0; flush_i = 1'b0;
        @(negedge clk_i);
        n_cmp++;
        if (fifo_af_count_o !== 3'd5 || fifo_ae_count_o !== 3'd1) begin
            n_err++; $display("FAIL cfg_load: got %0d/%0d want 5/1", fifo_af_count_o, fifo_ae_count_o);
        end
        step();
        @(negedge clk_i); step();
        rise_at = -1;
        data1_i = $urandom;
        for (int c = 0; c < 10; c++) begin
            req1_i = (fifo_cnt < 4'd5);
            @(negedge clk_i);
            if (fifo_af_i && rise_at < 0) begin
                rise_at = c;
                n_cmp++;
                if (irq_af_o !== 1'b0) begin
                    n_err++; $display("FAIL af_irq_early: got %b want 0", irq_af_o);
                end
            end else if (rise_at >= 0 && c == rise_at + 1) begin
                n_cmp++;
                if (irq_af_o !== 1'b1) begin
                    n_err++; $display("FAIL af_irq_set: got %b want 1", irq_af_o);
                end
            end
            step();
        end
        req1_i = 1'b0;
        n_cmp++;
        if (rise_at != 5) begin
            n_err++; $display("FAIL af_rise_cycle: got %0d want 5", rise_at);
        end
        irq_clr_i = 1'b1;
        @(negedge clk_i); step();
        irq_clr_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            n_cmp++;
            if (irq_af_o !== 1'b0 || fifo_af_i !== 1'b1) begin
                n_err++; $display("FAIL af_no_reset: got irq %b af %b want 0 1", irq_af_o, fifo_af_i);
            end
            step();
        end
    endtask

    task automatic test_set_beats_clear();
        int guard;
        guard = 0;
        while (fifo_cnt > 4'd1 && guard < 20) begin
            rd_en = 1'b1;
            @(negedge clk_i); step();
            guard++;
        end
        rd_en = 1'b0;
        n_cmp++;
        if (fifo_cnt !== 4'd1) begin
            n_err++; $display("FAIL drain_level: got %0d want 1", fifo_cnt);
        end
        irq_clr_i = 1'b1;
        @(negedge clk_i); step();
        irq_clr_i = 1'b0;
        @(negedge clk_i);
        n_cmp++;
        if (irq_ae_o !== 1'b1) begin
            n_err++; $display("FAIL set_beats_clear: got %b want 1", irq_ae_o);
        end
        step();
        irq_clr_i = 1'b1;
        @(negedge clk_i); step();
        irq_clr_i = 1'b0;
    endtask

    task automatic test_reset_mid_flush();
        flush_i = 1'b1;
        @(negedge clk_i); step();
        flush_i = 1'b0;
        #2;
        n_cmp++;
        if (fifo_clr_o !== 1'b1) begin
            n_err++; $display("FAIL midflush_in_clr: got %b want 1", fifo_clr_o);
        end
        rstn_i = 1'b0;
        #1;
        n_cmp++;
        if (fifo_clr_o !== 1'b0 || flush_busy_o !== 1'b0) begin
            n_err++; $display("FAIL midflush_async: got clr %b busy %b want 0 0", fifo_clr_o, flush_busy_o);
        end
        model_reset();
        @(posedge clk_i); #1;
        rstn_i = 1'b1;
        req0_i = 1'b1;
        @(negedge clk_i);
        n_cmp++;
        if (gnt0_o !== 1'b1 || flush_busy_o !== 1'b0) begin
            n_err++; $display("FAIL midflush_regrant: got gnt0 %b busy %b want 1 0", gnt0_o, flush_busy_o);
        end
        step();
        req0_i = 1'b0;
    endtask

    task automatic test_random();
        int g;
        for (int i = 0; i < 400; i++) begin
            req0_i    = 1'($urandom_range(0, 1));
            req1_i    = 1'($urandom_range(0, 1));
            data0_i   = $urandom;
            data1_i   = $urandom;
            flush_i   = ($urandom_range(0, 15) == 0);
            cfg_we_i  = ($urandom_range(0, 19) == 0);
            cfg_af_i  = 3'($urandom_range(0, 7));
            cfg_ae_i  = 3'($urandom_range(0, 7));
            irq_clr_i = ($urandom_range(0, 7) == 0);
            rd_en     = ($urandom_range(0, 2) == 0);
            @(negedge clk_i);
            g = exp_gnt();
            n_cmp++;
            if ({gnt1_o, gnt0_o} !== gnt_bits(g) || fifo_wr_o !== 1'(g >= 0)) begin
                n_err++; $display("FAIL rnd_grant[%0d]: got %b wr %b want %b", i, {gnt1_o, gnt0_o}, fifo_wr_o, gnt_bits(g));
            end
            if (g >= 0) begin
                n_cmp++;
                if (fifo_data_o !== ((g == 1) ? data1_i : data0_i)) begin
                    n_err++; $display("FAIL rnd_data[%0d]: got %h want %h", i, fifo_data_o, (g == 1) ? data1_i : data0_i);
                end
            end
            n_cmp++;
            if (fifo_clr_o !== 1'(m_busy == 2) || flush_busy_o !== 1'(m_busy != 0)) begin
                n_err++; $display("FAIL rnd_flush[%0d]: got clr %b busy %b want %b %b", i, fifo_clr_o, flush_busy_o,
                                  (m_busy == 2), (m_busy != 0));
            end
            n_cmp++;
            if (irq_af_o !== m_irq_af || irq_ae_o !== m_irq_ae) begin
                n_err++; $display("FAIL rnd_irq[%0d]: got %b%b want %b%b", i, irq_af_o, irq_ae_o, m_irq_af, m_irq_ae);
            end
            n_cmp++;
            if (fifo_af_count_o !== m_af_thr || fifo_ae_count_o !== m_ae_thr) begin
                n_err++; $display("FAIL rnd_thr[%0d]: got %0d/%0d want %0d/%0d", i, fifo_af_count_o,
                                  fifo_ae_count_o, m_af_thr, m_ae_thr);
            end
            step();
        end
        req0_i = 1'b0; req1_i = 1'b0; flush_i = 1'b0; cfg_we_i = 1'b0; irq_clr_i = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_flush();
        test_af_irq();
        test_set_beats_clear();
        test_reset_mid_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
